// File: rtl/usb_gpx_conditioner_if.sv
// Avalon-MM slave bus for the GPX conditioner register file.
// Word addressed, no read strobe, read latency 1, no wait states.
interface usb_gpx_conditioner_if;
   logic [1:0]  address;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport slave (
      input  address,
      input  write,
      input  writedata,
      output readdata
   );

   modport master (
      output address,
      output write,
      output writedata,
      input  readdata
   );
endinterface

// File: rtl/usb_gpx_conditioner.sv
// GPX pin conditioner.
// The raw pin passes through a two-flop synchroniser and then a glitch filter
// that only accepts a new level after it has persisted for FILTER_CYCLES
// synchronised cycles. Accepted rising/falling edges are captured in a W1C
// register and combined with a mask to form a level interrupt.
//
// Register map (word addresses):
//   0 DATA  RO   bit0 = filtered level
//   1 MASK  RW   bits[1:0] = {fall_en, rise_en}
//   2 --         reads 0, writes ignored
//   3 EDGE  W1C  bit0 = rise captured, bit1 = fall captured
module usb_gpx_conditioner #(
   parameter int unsigned FILTER_CYCLES = 4,
   parameter int unsigned CNT_W         = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_gpx_in,
   output logic                 o_gpx_clean,
   output logic                 o_irq,
   usb_gpx_conditioner_if.slave bus
);

   localparam logic [CNT_W-1:0] TermCnt = CNT_W'(FILTER_CYCLES - 1);

   localparam logic [1:0] AddrData = 2'd0;
   localparam logic [1:0] AddrMask = 2'd1;
   localparam logic [1:0] AddrRsvd = 2'd2;
   localparam logic [1:0] AddrEdge = 2'd3;

   // Synchroniser
   logic r_sync1;
   logic r_sync2;

   // Glitch filter
   logic             r_clean;
   logic [CNT_W-1:0] r_cnt;
   logic             w_clean_d;
   logic [CNT_W-1:0] w_cnt_d;
   logic             w_rise_evt;
   logic             w_fall_evt;

   // Register file
   logic [1:0]  r_mask;
   logic [1:0]  r_edge;
   logic [31:0] r_readdata;
   logic [1:0]  w_mask_d;
   logic [1:0]  w_edge_d;
   logic [1:0]  w_edge_clr;
   logic        w_wr_mask;
   logic        w_wr_edge;
   logic [31:0] w_readdata_d;

   // Only the low two write data bits reach any register.
   logic w_unused_wdata;
   assign w_unused_wdata = ^bus.writedata[31:2];

   // Two-flop synchroniser for the asynchronous pin.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_gpx_in;
         r_sync2 <= r_sync1;
      end
   end

   // Filter next state: count cycles the synchronised level disagrees with the
   // accepted level; any agreement restarts the count.
   always_comb begin
      w_clean_d  = r_clean;
      w_cnt_d    = r_cnt;
      w_rise_evt = 1'b0;
      w_fall_evt = 1'b0;
      if (r_sync2 == r_clean) begin
         w_cnt_d = '0;
      end else if (r_cnt == TermCnt) begin
         w_clean_d  = r_sync2;
         w_cnt_d    = '0;
         w_rise_evt = r_sync2;
         w_fall_evt = ~r_sync2;
      end else begin
         w_cnt_d = r_cnt + 1'b1;
      end
   end

   // Register write decode and next state; a capture beats a same-cycle clear.
   always_comb begin
      w_wr_mask  = bus.write && (bus.address == AddrMask);
      w_wr_edge  = bus.write && (bus.address == AddrEdge);
      w_mask_d   = w_wr_mask ? bus.writedata[1:0] : r_mask;
      w_edge_clr = w_wr_edge ? bus.writedata[1:0] : 2'b00;
      w_edge_d   = (r_edge & ~w_edge_clr) | {w_fall_evt, w_rise_evt};
   end

   // Read mux works on next-state values so readdata shows this edge's updates.
   always_comb begin
      w_readdata_d = '0;
      case (bus.address)
         AddrData: w_readdata_d[0]   = w_clean_d;
         AddrMask: w_readdata_d[1:0] = w_mask_d;
         AddrRsvd: w_readdata_d      = '0;
         AddrEdge: w_readdata_d[1:0] = w_edge_d;
         default:  w_readdata_d      = '0;
      endcase
   end

   // Filter, register file and read data state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_clean    <= 1'b0;
         r_cnt      <= '0;
         r_mask     <= 2'b00;
         r_edge     <= 2'b00;
         r_readdata <= '0;
      end else begin
         r_clean    <= w_clean_d;
         r_cnt      <= w_cnt_d;
         r_mask     <= w_mask_d;
         r_edge     <= w_edge_d;
         r_readdata <= w_readdata_d;
      end
   end

   assign o_gpx_clean  = r_clean;
   assign o_irq        = |(r_edge & r_mask);
   assign bus.readdata = r_readdata;

endmodule
